// File: rtl/scan_pkg.sv
// Shared state encoding and the rotate-priority digit search used by the scanner.
package scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_BLANK  = 2'd2
  } state_t;

  // Returns {wrap, idx}: first set bit strictly after cur, modulo 4.
  // A single-bit mask finds cur itself on the fourth step and counts as a wrap.
  function automatic logic [2:0] next_idx(input logic [3:0] mask, input logic [1:0] cur);
    logic [2:0] res;
    logic [1:0] j;
    logic       found;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      j = cur + 2'(k);
      if (!found && mask[j]) begin
        found = 1'b1;
        res   = {(j <= cur), j};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/next_digit_sel.sv
// Combinational picker: next enabled index after cur, with wrap and empty-mask flags.
module next_digit_sel
  import scan_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  output logic [1:0] idx,
  output logic       wrap,
  output logic       none
);

  logic [2:0] pick;

  assign pick = next_idx(mask, cur);
  assign idx  = pick[1:0];
  assign wrap = pick[2];
  assign none = (mask == 4'b0000);

endmodule

// File: rtl/digit_scan_sequencer.sv
// Timed round-robin scanner driving select/enable of a 2-to-4 decoder,
// with per-digit dwell, optional blanking gap and masked-out digit skipping.
module digit_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL = 8,
  parameter int BLANK = 2,
  parameter int CW    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] mask,
  output logic [1:0] w,
  output logic       en,
  output logic       digit_start,
  output logic       frame_done
);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    cur;
  logic [1:0]    sel_idx;
  logic          sel_wrap;
  logic          sel_none;
  logic          dwell_end;
  logic          slot_end;

  // Searching after index 3 yields the lowest set bit, which is the IDLE start digit.
  assign cur = (state == S_IDLE) ? 2'd3 : w;

  next_digit_sel u_sel (
    .mask (mask),
    .cur  (cur),
    .idx  (sel_idx),
    .wrap (sel_wrap),
    .none (sel_none)
  );

  assign dwell_end = (state == S_ACTIVE) && (cnt == DWELL_LAST);
  assign slot_end  = (dwell_end && (BLANK == 0)) ||
                     ((state == S_BLANK) && (cnt == BLANK_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      w           <= 2'd0;
      en          <= 1'b0;
      digit_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      digit_start <= 1'b0;
      frame_done  <= 1'b0;
      if (state == S_IDLE) begin
        cnt <= '0;
        if (run && !sel_none) begin
          state       <= S_ACTIVE;
          w           <= sel_idx;
          en          <= 1'b1;
          digit_start <= 1'b1;
        end else begin
          w  <= 2'd0;
          en <= 1'b0;
        end
      end else if (!run || (slot_end && sel_none) || (state != S_ACTIVE && state != S_BLANK)) begin
        state <= S_IDLE;
        cnt   <= '0;
        w     <= 2'd0;
        en    <= 1'b0;
      end else if (slot_end) begin
        state       <= S_ACTIVE;
        cnt         <= '0;
        w           <= sel_idx;
        en          <= 1'b1;
        digit_start <= 1'b1;
        frame_done  <= sel_wrap;
      end else if (dwell_end) begin
        state <= S_BLANK;
        cnt   <= '0;
        en    <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Bench for digit_scan_sequencer: a blanking instance and a no-blanking instance
// share stimulus and are checked every cycle against a slot-position model.
module tb_digit_scan_sequencer;

  localparam int D  = 8;
  localparam int B0 = 2;
  localparam int B1 = 0;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b0;
  logic [3:0] mask  = 4'b0000;

  logic [1:0] w_a, w_b;
  logic       en_a, en_b, ds_a, ds_b, fd_a, fd_b;

  always #5 clk = ~clk;

  digit_scan_sequencer #(.DWELL(D), .BLANK(B0), .CW(16)) dut_a (
    .clk(clk), .reset(reset), .run(run), .mask(mask),
    .w(w_a), .en(en_a), .digit_start(ds_a), .frame_done(fd_a)
  );

  digit_scan_sequencer #(.DWELL(D), .BLANK(B1), .CW(16)) dut_b (
    .clk(clk), .reset(reset), .run(run), .mask(mask),
    .w(w_b), .en(en_b), .digit_start(ds_b), .frame_done(fd_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a scanning flag, the current digit, and the position inside its
  // DWELL+BLANK slot; enable is simply "position < DWELL".
  bit m_on[2];
  int m_cur[2];
  int m_pos[2];
  bit m_ds[2];
  bit m_fd[2];

  task automatic model_step(input int i, input int b);
    int lst[$];
    int nxt;
    bit wrap;
    m_ds[i] = 1'b0;
    m_fd[i] = 1'b0;
    for (int k = 0; k < 4; k++) if (mask[k]) lst.push_back(k);
    if (reset) begin
      m_on[i] = 1'b0; m_cur[i] = 0; m_pos[i] = 0;
    end else if (!m_on[i]) begin
      if (run && lst.size() > 0) begin
        m_on[i] = 1'b1; m_cur[i] = lst[0]; m_pos[i] = 0; m_ds[i] = 1'b1;
      end
    end else if (!run) begin
      m_on[i] = 1'b0; m_cur[i] = 0; m_pos[i] = 0;
    end else if (m_pos[i] == D + b - 1) begin
      if (lst.size() == 0) begin
        m_on[i] = 1'b0; m_cur[i] = 0; m_pos[i] = 0;
      end else begin
        nxt  = lst[0];
        wrap = 1'b1;
        foreach (lst[k]) if (wrap && lst[k] > m_cur[i]) begin
          nxt  = lst[k];
          wrap = 1'b0;
        end
        m_fd[i] = wrap; m_cur[i] = nxt; m_pos[i] = 0; m_ds[i] = 1'b1;
      end
    end else begin
      m_pos[i]++;
    end
  endtask

  function automatic logic [31:0] exp_w(input int i);
    return m_on[i] ? 32'(m_cur[i]) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_en(input int i);
    return (m_on[i] && m_pos[i] < D) ? 32'd1 : 32'd0;
  endfunction

  always @(posedge clk) begin
    model_step(0, B0);
    model_step(1, B1);
  end

  always @(negedge clk) begin
    check("model_w_a",  32'(w_a),  exp_w(0));
    check("model_en_a", 32'(en_a), exp_en(0));
    check("model_ds_a", 32'(ds_a), 32'(m_ds[0]));
    check("model_fd_a", 32'(fd_a), 32'(m_fd[0]));
    check("model_w_b",  32'(w_b),  exp_w(1));
    check("model_en_b", 32'(en_b), exp_en(1));
    check("model_ds_b", 32'(ds_b), 32'(m_ds[1]));
    check("model_fd_b", 32'(fd_b), 32'(m_fd[1]));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_w", 32'(w_a), 0);
    check("rst_en", 32'(en_a), 0);
    check("rst_ds", 32'(ds_a), 0);

    // Full mask, blanking and no-blanking instances side by side
    reset = 1'b0; run = 1'b1; mask = 4'b1111;
    tick(1);
    check("t1_first_w", 32'(w_a), 0);
    check("t1_first_ds", 32'(ds_a), 1);
    check("t1_first_fd", 32'(fd_a), 0);
    tick(8);
    check("t1_blank_en", 32'(en_a), 0);
    check("t1_blank_w", 32'(w_a), 0);
    check("t4_step_w", 32'(w_b), 1);
    check("t4_step_en", 32'(en_b), 1);
    tick(2);
    check("t1_second_w", 32'(w_a), 1);
    check("t1_second_ds", 32'(ds_a), 1);
    check("t1_second_fd", 32'(fd_a), 0);
    tick(30);
    check("t1_wrap_w", 32'(w_a), 0);
    check("t1_wrap_fd", 32'(fd_a), 1);
    check("t4_late_w", 32'(w_b), 1);

    // Alternating two-digit mask
    run = 1'b0;
    tick(1);
    check("t2_idle_en", 32'(en_a), 0);
    mask = 4'b1010; run = 1'b1;
    tick(1);
    check("t2_first_w", 32'(w_a), 1);
    check("t2_first_fd", 32'(fd_a), 0);
    tick(10);
    check("t2_w3", 32'(w_a), 3);
    check("t2_w3_fd", 32'(fd_a), 0);
    tick(10);
    check("t2_w1", 32'(w_a), 1);
    check("t2_w1_fd", 32'(fd_a), 1);

    // Single-bit mask wraps onto itself
    run = 1'b0;
    tick(1);
    mask = 4'b0100; run = 1'b1;
    tick(1);
    check("t3_first_fd", 32'(fd_a), 0);
    tick(8);
    check("t3_b_w", 32'(w_b), 2);
    check("t3_b_fd", 32'(fd_b), 1);
    tick(2);
    check("t3_a_w", 32'(w_a), 2);
    check("t3_a_ds", 32'(ds_a), 1);
    check("t3_a_fd", 32'(fd_a), 1);

    // Abort on run low during the third ACTIVE cycle at w=2
    run = 1'b0;
    tick(1);
    mask = 4'b1111; run = 1'b1;
    tick(1);
    tick(20);
    check("t5_at2_w", 32'(w_a), 2);
    tick(2);
    run = 1'b0;
    tick(1);
    check("t5_abort_en", 32'(en_a), 0);
    check("t5_abort_w", 32'(w_a), 0);
    check("t5_abort_fd", 32'(fd_a), 0);
    run = 1'b1;
    tick(1);
    check("t5_restart_w", 32'(w_a), 0);
    check("t5_restart_ds", 32'(ds_a), 1);

    // Reset in the blanking gap
    tick(8);
    check("t6_in_blank", 32'(en_a), 0);
    reset = 1'b1; mask = 4'b1100;
    tick(1);
    check("t6_rst_w", 32'(w_a), 0);
    check("t6_rst_en", 32'(en_a), 0);
    check("t6_rst_ds", 32'(ds_a), 0);
    reset = 1'b0;
    tick(1);
    check("t6_after_w", 32'(w_a), 2);
    check("t6_after_ds", 32'(ds_a), 1);

    // Mask cleared mid-dwell: slot completes, then idle
    tick(3);
    mask = 4'b0000;
    tick(4);
    check("t6b_dwell_en", 32'(en_a), 1);
    tick(2);
    check("t6b_blank_en", 32'(en_a), 0);
    check("t6b_blank_w", 32'(w_a), 2);
    tick(1);
    check("t6b_idle_w", 32'(w_a), 0);
    check("t6b_idle_ds", 32'(ds_a), 0);
    tick(3);
    check("t6b_stay_en", 32'(en_a), 0);

    run = 1'b0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
